// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit.
//   state_e       : request-sequencer states (IDLE issues, RESP holds a load result)
//   DEFAULT_DEPTH : default request queue depth
package mem_access_pkg;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;
endpackage

// File: rtl/mem_access_unit_fifo.sv
// request_fifo: in-order request queue, DEPTH entries of EW bits.
//   clk, reset        : clock, async active-high reset (empties the queue)
//   push / din        : enqueue din; ignored while full
//   pop  / dout       : dequeue head; dout is the current head (registered storage)
//   full, empty, count: occupancy status
module request_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int EW    = 2*WIDTH + 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [EW-1:0] din,
  input  logic          pop,
  output logic [EW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  // A full queue never accepts, even if the head leaves this same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  // Storage is not reset; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: queues load/store requests and sequences them onto a
// single-port data_memory with a combinational read path.
//   clk, reset                         : clock, async active-high reset
//   req_valid/req_ready/req_write/
//   req_address/req_data               : request handshake (store when req_write=1)
//   resp_valid/resp_ready/resp_data    : load result handshake
//   mem_write_enable/mem_address/
//   mem_data_out/mem_data_in           : data_memory port
//   pending                            : queue occupancy
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [WIDTH-1:0]           req_address,
  input  logic [WIDTH-1:0]           req_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       mem_write_enable,
  output logic [WIDTH-1:0]           mem_address,
  output logic [WIDTH-1:0]           mem_data_out,
  input  logic [WIDTH-1:0]           mem_data_in,
  output logic [$clog2(DEPTH+1)-1:0] pending
);
  typedef struct packed {
    logic             write;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] data;
  } req_t;

  state_e state;
  req_t   push_req, head;
  logic   full, empty, issue;

  assign push_req = '{write: req_write, address: req_address, data: req_data};

  request_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid && !full),
    .din   (push_req),
    .pop   (issue),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  // The head is serviced in exactly one cycle while IDLE: a store writes
  // and pops, a load samples the read data and pops. RESP stalls issue.
  assign issue            = (state == IDLE) && !empty;
  assign req_ready        = !full;
  assign resp_valid       = (state == RESP);
  assign mem_write_enable = issue && head.write;
  assign mem_address      = issue ? head.address : '0;
  assign mem_data_out     = issue ? head.data    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      resp_data <= '0;
    end else begin
      unique case (state)
        IDLE: if (issue && !head.write) begin
          resp_data <= mem_data_in;
          state     <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic       clk, reset;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_address, req_data;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_data;
  logic       mem_write_enable;
  logic [7:0] mem_address, mem_data_out, mem_data_in;
  logic [2:0] pending;

  mem_access_unit #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory stand-in: synchronous write, combinational read
  logic [7:0] tbmem [256];
  always @(posedge clk) if (mem_write_enable) tbmem[mem_address] <= mem_data_out;
  assign mem_data_in = tbmem[mem_address];

  // Reference model: memory image updated in request order; expected writes
  // and load results queued at acceptance time (the unit is strictly in order).
  logic [7:0]  model_mem [256];
  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  int   n_cmp = 0, n_err = 0, n_wr = 0, w0;
  logic acc, rnd_rr;
  logic [7:0] hold_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, return 1 time unit after the next posedge.
  task automatic step();
    @(negedge clk);
    acc = 1'b0;
    if (mem_write_enable === 1'b1) begin
      n_wr++;
      if (wq.size() == 0) chk("wr_unexp", 32'(mem_write_enable), 32'd0);
      else chk("wr", 32'({mem_address, mem_data_out}), 32'(wq.pop_front()));
    end
    if (resp_valid === 1'b1 && resp_ready) begin
      if (rq.size() == 0) chk("resp_unexp", 32'(resp_valid), 32'd0);
      else chk("resp", 32'(resp_data), 32'(rq.pop_front()));
    end
    if (req_valid && req_ready === 1'b1 && !reset) begin
      acc = 1'b1;
      if (req_write) begin
        model_mem[req_address] = req_data;
        wq.push_back({req_address, req_data});
      end else begin
        rq.push_back(model_mem[req_address]);
      end
    end
    @(posedge clk);
    #1;
    if (rnd_rr) resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = w; req_address = a; req_data = d;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step();
    chk("accept", 32'(acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    resp_ready = 1'b1; req_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wq.size() == 0 && rq.size() == 0 && resp_valid === 1'b0 && pending == 3'd0) break;
      step();
    end
    chk("drain_left", 32'(wq.size() + rq.size()), 32'd0);
    chk("drain_pend", 32'(pending), 32'd0);
    chk("idle_mem_port", 32'({mem_address, mem_data_out, mem_write_enable}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rnd_rr = 1'b0; acc = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
    resp_ready = 1'b1;
    #2;
    chk("rst_pending",   32'(pending), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp",      32'({resp_valid, resp_data}), 32'd0);
    chk("rst_mwe",       32'(mem_write_enable), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Store then load to the same address, back to back
    w0 = n_wr;
    send(1'b1, 8'h10, 8'hA5);
    send(1'b0, 8'h10, 8'h00);
    drain();
    chk("st_ld_one_write", 32'(n_wr - w0), 32'd1);

    // Ten stores then ten loads: forces pointer wrap in both directions
    for (int a = 0; a < 10; a++) send(1'b1, 8'(a), 8'(a + 1));
    for (int a = 0; a < 10; a++) send(1'b0, 8'(a), 8'h00);
    drain();
    for (int a = 10; a < 16; a++) send(1'b1, 8'(a), 8'(8'hC0 + a));
    drain();

    // Six loads with the consumer stalled: queue fills, sixth request waits
    resp_ready = 1'b0;
    for (int a = 0; a < 5; a++) send(1'b0, 8'(a), 8'h00);
    chk("full_pending",   32'(pending), 32'd4);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    chk("full_resp_vld",  32'(resp_valid), 32'd1);
    hold_v = rq[0];
    req_valid = 1'b1; req_write = 1'b0; req_address = 8'd5; req_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_acc",  32'(acc), 32'd0);
      chk("hold_data",  32'(resp_data), 32'(hold_v));
      chk("hold_port",  32'({mem_write_enable, mem_address}), 32'd0);
      chk("hold_pend",  32'(pending), 32'd4);
    end
    resp_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step();
    chk("stall_release", 32'(acc), 32'd1);
    req_valid = 1'b0;
    drain();

    // Randomized mix with request gaps and consumer back-pressure
    rnd_rr = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    end
    rnd_rr = 1'b0;
    drain();

    // Reset while holding a response with three loads queued
    resp_ready = 1'b0;
    for (int a = 1; a < 5; a++) send(1'b0, 8'(a), 8'h00);
    chk("pre_rst_pend", 32'(pending), 32'd3);
    chk("pre_rst_resp", 32'(resp_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_resp",      32'({resp_valid, resp_data}), 32'd0);
    chk("mid_rst_pending",   32'(pending), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_mwe",       32'(mem_write_enable), 32'd0);
    wq.delete();
    rq.delete();
    w0 = n_wr;
    step(); step();
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_writes", 32'(n_wr - w0), 32'd0);
    chk("post_rst_state",  32'({pending, resp_valid}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
